// File: rtl/bmem_pkg.sv
// bmem_pkg: shared types and constants for the bmem burst interface.
// Used by the memory-side responder and the CPU-side cache adapter.
package bmem_pkg;

  localparam int unsigned BMEM_ADDR_WIDTH  = 32;
  localparam int unsigned BMEM_DATA_WIDTH  = 64;
  localparam int unsigned BMEM_BURST_LEN   = 4;
  localparam int unsigned BMEM_LINE_BYTES  = 32;
  localparam int unsigned BMEM_OFFSET_BITS = 5;
  localparam int unsigned BMEM_BEAT_BITS   = 2;

  typedef logic [BMEM_DATA_WIDTH-1:0]                  beat_t;
  typedef logic [BMEM_ADDR_WIDTH-BMEM_OFFSET_BITS-1:0] line_addr_t;
  typedef logic [BMEM_BEAT_BITS-1:0]                   burst_cnt_t;

  // Read-return sequencer state.
  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_state_t;

  // One step of the x^16+x^14+x^13+x^11+1 Fibonacci LFSR (right-shifting form).
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/bmem_req_fifo.sv
// bmem_req_fifo: in-order queue of pending read requests {line address, timer}.
// Every entry's timer counts down each cycle and saturates at 0; a push loads
// the entry's start value.
// Ports:
//   clk, rst (sync, active-low)
//   push, push_addr, push_timer : enqueue one request
//   pop                         : drop the head entry
//   head_addr, head_timer       : head entry contents
//   head_valid, full, count     : occupancy
module bmem_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 27,
  parameter int unsigned TW    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [AW-1:0]          push_addr,
  input  logic [TW-1:0]          push_timer,
  input  logic                   pop,
  output logic [AW-1:0]          head_addr,
  output logic [TW-1:0]          head_timer,
  output logic                   head_valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [AW-1:0] addr_q  [DEPTH];
  logic [TW-1:0] timer_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointers and occupancy; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
    end
  end

  // Entry storage; stale entries after a flush are harmless since count gates them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (timer_q[PW'(i)] != '0) timer_q[PW'(i)] <= timer_q[PW'(i)] - TW'(1);
    end
    if (push) begin
      addr_q[wr_ptr]  <= push_addr;
      timer_q[wr_ptr] <= push_timer;
    end
  end

  assign head_addr  = addr_q[rd_ptr];
  assign head_timer = timer_q[rd_ptr];
  assign head_valid = (count != '0);
  assign full       = (count == (PW+1)'(DEPTH));

endmodule

// File: rtl/bmem_responder.sv
// bmem_responder: memory-side end of the bmem burst interface.
// Accepts single-cycle line reads and 4-beat write bursts, returns read bursts
// in order after a fixed latency from an on-chip backing array.
// Ports:
//   clk, rst (sync, active-low)
//   bmem_addr   : request byte address, low 5 bits ignored
//   bmem_read   : read request
//   bmem_write  : write beat valid (first beat needs bmem_ready)
//   bmem_wdata  : write beat
//   bmem_ready  : request accept enable (from registers only)
//   bmem_raddr  : line-aligned address of the returning beat
//   bmem_rdata  : read beat
//   bmem_rvalid : read beat valid
// Build option: define BMEM_RESP_BACKPRESSURE_EN to add LFSR-driven ready stalls.
module bmem_responder
  import bmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned BURST_LEN    = 4,
  parameter int unsigned MEM_LINES    = 256,
  parameter int unsigned READ_LATENCY = 6,
  parameter int unsigned QUEUE_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] bmem_addr,
  input  logic                  bmem_read,
  input  logic                  bmem_write,
  input  logic [DATA_WIDTH-1:0] bmem_wdata,
  output logic                  bmem_ready,
  output logic [ADDR_WIDTH-1:0] bmem_raddr,
  output logic [DATA_WIDTH-1:0] bmem_rdata,
  output logic                  bmem_rvalid
);

  localparam int unsigned LINE_AW = ADDR_WIDTH - BMEM_OFFSET_BITS;
  localparam int unsigned IDX_W   = $clog2(MEM_LINES);
  localparam int unsigned BEAT_W  = $clog2(BURST_LEN);
  localparam int unsigned TIMER_W = $clog2(READ_LATENCY + 1);
  localparam int unsigned CNT_W   = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned WORDS   = MEM_LINES * BURST_LEN;
  localparam int unsigned WORD_AW = IDX_W + BEAT_W;

  localparam logic [BEAT_W-1:0]           LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
  localparam logic [BMEM_OFFSET_BITS-1:0] OFFSET_ZERO = '0;
  // The timer reaches 0 on the edge where the requester samples beat 0, so the
  // beat register must load while two cycles remain.
  localparam logic [TIMER_W-1:0]          DUE_TIMER   = TIMER_W'(2);

  logic [DATA_WIDTH-1:0] mem [WORDS];

  rd_state_t          rd_state;
  logic [BEAT_W-1:0]  rd_beat;
  logic               wr_active;
  logic [BEAT_W-1:0]  wr_beat;
  logic [IDX_W-1:0]   wr_idx;

  logic               push;
  logic               pop;
  logic               q_full;
  logic               head_valid;
  logic [LINE_AW-1:0] head_line;
  logic [TIMER_W-1:0] head_timer;
  logic [CNT_W-1:0]   q_count;

  logic               bp_ok;
  logic               accept_wr;
  logic               accept_rd;
  logic               head_due;
  logic               emit;
  logic               last_beat;
  logic [BEAT_W-1:0]  emit_beat;
  logic [WORD_AW-1:0] rd_word;
  logic [WORD_AW-1:0] wr_word;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^bmem_addr[BMEM_OFFSET_BITS-1:0];

`ifdef BMEM_RESP_BACKPRESSURE_EN
  logic [15:0] lfsr;

  // Free-running stall source.
  always_ff @(posedge clk) begin
    if (!rst) lfsr <= 16'hACE1;
    else      lfsr <= lfsr16_next(lfsr);
  end

  assign bp_ok = (lfsr[1:0] != 2'b00);
`else
  assign bp_ok = 1'b1;
`endif

  assign bmem_ready = rst && !wr_active && (q_count < CNT_W'(QUEUE_DEPTH)) && bp_ok;

  // Request acceptance and read/write port addressing.
  always_comb begin
    accept_wr = bmem_write && bmem_ready;
    accept_rd = bmem_read && bmem_ready && !bmem_write;
    push      = accept_rd && !q_full;
    head_due  = head_valid && (head_timer <= DUE_TIMER);
    emit      = (rd_state == RD_BURST) || head_due;
    emit_beat = (rd_state == RD_BURST) ? rd_beat : '0;
    last_beat = (rd_state == RD_BURST) && (rd_beat == LAST_BEAT);
    pop       = last_beat;
    rd_word   = {head_line[IDX_W-1:0], emit_beat};
    wr_word   = wr_active ? {wr_idx, wr_beat}
                          : {bmem_addr[BMEM_OFFSET_BITS +: IDX_W], BEAT_W'(0)};
  end

  bmem_req_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .AW    (LINE_AW),
    .TW    (TIMER_W)
  ) u_req_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_addr  (bmem_addr[ADDR_WIDTH-1:BMEM_OFFSET_BITS]),
    .push_timer (TIMER_W'(READ_LATENCY)),
    .pop        (pop),
    .head_addr  (head_line),
    .head_timer (head_timer),
    .head_valid (head_valid),
    .full       (q_full),
    .count      (q_count)
  );

  // Backing array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst && (accept_wr || wr_active)) mem[wr_word] <= bmem_wdata;
  end

  // Write-burst tracking, read-return sequencer and registered read outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_active   <= 1'b0;
      wr_beat     <= '0;
      wr_idx      <= '0;
      rd_state    <= RD_IDLE;
      rd_beat     <= '0;
      bmem_rvalid <= 1'b0;
      bmem_rdata  <= '0;
      bmem_raddr  <= '0;
    end else begin
      if (accept_wr) begin
        wr_active <= 1'b1;
        wr_beat   <= BEAT_W'(1);
        wr_idx    <= bmem_addr[BMEM_OFFSET_BITS +: IDX_W];
      end else if (wr_active) begin
        wr_beat <= wr_beat + BEAT_W'(1);
        if (wr_beat == LAST_BEAT) wr_active <= 1'b0;
      end

      case (rd_state)
        RD_IDLE: begin
          if (head_due) begin
            rd_state <= RD_BURST;
            rd_beat  <= BEAT_W'(1);
          end
        end
        RD_BURST: begin
          rd_beat <= rd_beat + BEAT_W'(1);
          if (last_beat) rd_state <= RD_IDLE;
        end
        default: rd_state <= RD_IDLE;
      endcase

      bmem_rvalid <= emit;
      if (emit) begin
        bmem_rdata <= mem[rd_word];
        bmem_raddr <= {head_line, OFFSET_ZERO};
      end
    end
  end

endmodule

// File: tb/tb_bmem_responder.sv
// tb_bmem_responder: directed self-checking bench for bmem_responder.
// Timing notation: "T+k" is the value the requester samples at edge T+k,
// observed here 1ns after edge T+k-1.
module tb_bmem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_write;
  logic [63:0] bmem_wdata;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;

  int checks = 0;
  int errs   = 0;

  logic [63:0] da  [4];
  logic [63:0] dn  [4];
  logic [63:0] dol [4];
  logic [63:0] dc  [4];
  logic [63:0] db  [16];

  bmem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finish", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bmem_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (bmem_ready !== 1'b1) begin
      checks++;
      errs++;
      $display("FAIL ready_timeout: ready=%b after %0d cycles, want 1", bmem_ready, n);
    end
  endtask

  // Stimulus only: one 4-beat write burst, optionally with a colliding read.
  task automatic write_line(input logic [31:0] addr, input logic [63:0] d0, d1, d2, d3,
                            input logic also_read);
    bmem_addr  = addr;
    bmem_write = 1'b1;
    bmem_read  = also_read;
    bmem_wdata = d0;
    wait_ready();
    tick();
    bmem_read  = 1'b0;
    bmem_wdata = d1;
    tick();
    bmem_wdata = d2;
    tick();
    bmem_wdata = d3;
    tick();
    bmem_write = 1'b0;
  endtask

  // One read; expects beats at T+6..T+9 and nothing at T+1..T+5 and T+10.
  task automatic test_read_line(input string name, input logic [31:0] addr,
                                input logic [31:0] exp_raddr,
                                input logic [63:0] d0, d1, d2, d3);
    logic [63:0] exp_d [4];
    logic        exp_v;
    exp_d = '{d0, d1, d2, d3};
    bmem_addr = addr;
    bmem_read = 1'b1;
    wait_ready();
    tick();
    bmem_read = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      exp_v = (k >= 6) && (k <= 9);
      checks++;
      if (bmem_rvalid !== exp_v) begin
        errs++;
        $display("FAIL %s rvalid T+%0d: got %b want %b", name, k, bmem_rvalid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (bmem_rdata !== exp_d[k-6] || bmem_raddr !== exp_raddr) begin
          errs++;
          $display("FAIL %s beat %0d: got %h @%h want %h @%h", name, k - 6,
                   bmem_rdata, bmem_raddr, exp_d[k-6], exp_raddr);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (bmem_ready !== 1'b0) begin errs++; $display("FAIL reset_ready: got %b want 0", bmem_ready); end
    checks++;
    if (bmem_rvalid !== 1'b0) begin errs++; $display("FAIL reset_rvalid: got %b want 0", bmem_rvalid); end
    checks++;
    if (bmem_rdata !== 64'd0) begin errs++; $display("FAIL reset_rdata: got %h want 0", bmem_rdata); end
    checks++;
    if (bmem_raddr !== 32'd0) begin errs++; $display("FAIL reset_raddr: got %h want 0", bmem_raddr); end
    rst = 1'b1;
    #1;
    checks++;
    if (bmem_ready !== 1'b1) begin errs++; $display("FAIL reset_release_ready: got %b want 1", bmem_ready); end
    tick();
  endtask

  task automatic test_write_read();
    bmem_addr  = 32'h100;
    bmem_write = 1'b1;
    bmem_wdata = da[0];
    wait_ready();
    tick();
    for (int b = 1; b < 4; b++) begin
      checks++;
      if (bmem_ready !== 1'b0) begin
        errs++;
        $display("FAIL wr_ready_busy T+%0d: got %b want 0", b, bmem_ready);
      end
      bmem_wdata = da[b];
      tick();
    end
    bmem_write = 1'b0;
`ifndef BMEM_RESP_BACKPRESSURE_EN
    checks++;
    if (bmem_ready !== 1'b1) begin errs++; $display("FAIL wr_ready_release T+4: got %b want 1", bmem_ready); end
`endif
    test_read_line("read_0x100", 32'h100, 32'h100, da[0], da[1], da[2], da[3]);
  endtask

  task automatic test_read_unaligned();
    test_read_line("read_0x104", 32'h104, 32'h100, da[0], da[1], da[2], da[3]);
    test_read_line("alias_0x2108", 32'h2108, 32'h2100, da[0], da[1], da[2], da[3]);
  endtask

`ifndef BMEM_RESP_BACKPRESSURE_EN
  task automatic test_back_to_back();
    logic        exp_v;
    logic        exp_rdy;
    int          idx;
    logic [31:0] exp_a;
    for (int i = 0; i < 4; i++) begin
      write_line(32'h200 + 32'(i) * 32'h20, db[4*i], db[4*i+1], db[4*i+2], db[4*i+3], 1'b0);
    end
    bmem_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bmem_addr = 32'h200 + 32'(i) * 32'h20;
      checks++;
      if (bmem_ready !== 1'b1) begin errs++; $display("FAIL b2b_accept %0d: ready=%b want 1", i, bmem_ready); end
      tick();
    end
    bmem_read = 1'b0;
    for (int k = 4; k <= 23; k++) begin
      exp_rdy = (k >= 9);
      checks++;
      if (bmem_ready !== exp_rdy) begin
        errs++;
        $display("FAIL b2b_ready T+%0d: got %b want %b", k, bmem_ready, exp_rdy);
      end
      exp_v = (k >= 6) && (k <= 21);
      checks++;
      if (bmem_rvalid !== exp_v) begin
        errs++;
        $display("FAIL b2b_rvalid T+%0d: got %b want %b", k, bmem_rvalid, exp_v);
      end
      if (exp_v) begin
        idx   = k - 6;
        exp_a = 32'h200 + 32'(idx / 4) * 32'h20;
        checks++;
        if (bmem_rdata !== db[idx] || bmem_raddr !== exp_a) begin
          errs++;
          $display("FAIL b2b_beat T+%0d: got %h @%h want %h @%h", k, bmem_rdata, bmem_raddr,
                   db[idx], exp_a);
        end
      end
      tick();
    end
  endtask

  task automatic test_read_then_write();
    logic exp_v;
    write_line(32'h300, dol[0], dol[1], dol[2], dol[3], 1'b0);
    bmem_addr = 32'h300;
    bmem_read = 1'b1;
    checks++;
    if (bmem_ready !== 1'b1) begin errs++; $display("FAIL rtw_read_accept: ready=%b want 1", bmem_ready); end
    tick();
    bmem_read  = 1'b0;
    bmem_write = 1'b1;
    bmem_wdata = dn[0];
    checks++;
    if (bmem_ready !== 1'b1) begin errs++; $display("FAIL rtw_write_accept: ready=%b want 1", bmem_ready); end
    tick();
    bmem_wdata = dn[1];
    tick();
    bmem_wdata = dn[2];
    tick();
    bmem_wdata = dn[3];
    tick();
    bmem_write = 1'b0;
    for (int k = 5; k <= 10; k++) begin
      exp_v = (k >= 6) && (k <= 9);
      checks++;
      if (bmem_rvalid !== exp_v) begin
        errs++;
        $display("FAIL rtw_rvalid T+%0d: got %b want %b", k, bmem_rvalid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (bmem_rdata !== dn[k-6] || bmem_raddr !== 32'h300) begin
          errs++;
          $display("FAIL rtw_beat %0d: got %h @%h want %h @300", k - 6, bmem_rdata, bmem_raddr, dn[k-6]);
        end
      end
      tick();
    end
  endtask
`endif

  task automatic test_reset_mid_burst();
    bmem_addr = 32'h100;
    bmem_read = 1'b1;
    wait_ready();
    tick();
    bmem_read = 1'b0;
    repeat (7) tick();
    checks++;
    if (bmem_rvalid !== 1'b1 || bmem_rdata !== da[2]) begin
      errs++;
      $display("FAIL rmb_beat2: got v=%b %h want v=1 %h", bmem_rvalid, bmem_rdata, da[2]);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bmem_rvalid !== 1'b0 || bmem_ready !== 1'b0 || bmem_rdata !== 64'd0 || bmem_raddr !== 32'd0) begin
      errs++;
      $display("FAIL rmb_in_reset: got v=%b rdy=%b d=%h a=%h want all 0", bmem_rvalid, bmem_ready,
               bmem_rdata, bmem_raddr);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bmem_ready !== 1'b1) begin errs++; $display("FAIL rmb_release_ready: got %b want 1", bmem_ready); end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (bmem_rvalid !== 1'b0) begin
        errs++;
        $display("FAIL rmb_no_beats cycle %0d: rvalid=%b want 0", k, bmem_rvalid);
      end
    end
    test_read_line("rmb_preserved", 32'h100, 32'h100, da[0], da[1], da[2], da[3]);
  endtask

  task automatic test_rw_collision();
    write_line(32'h400, dc[0], dc[1], dc[2], dc[3], 1'b1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bmem_rvalid !== 1'b0) begin
        errs++;
        $display("FAIL coll_dropped_read cycle %0d: rvalid=%b want 0", k, bmem_rvalid);
      end
      tick();
    end
    test_read_line("coll_data", 32'h400, 32'h400, dc[0], dc[1], dc[2], dc[3]);
  endtask

`ifdef BMEM_RESP_BACKPRESSURE_EN
  task automatic test_backpressure();
    int low = 0;
    for (int k = 0; k < 400; k++) begin
      if (bmem_ready !== 1'b1) low++;
      tick();
    end
    checks++;
    if (low < 60 || low > 140) begin
      errs++;
      $display("FAIL bp_stall_rate: %0d of 400 cycles low, want 60..140", low);
    end
  endtask
`endif

  initial begin
    rst        = 1'b0;
    bmem_addr  = '0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = '0;
    for (int b = 0; b < 4; b++) begin
      da[b]  = 64'hA0A0_0000_0000_0000 + 64'(b);
      dn[b]  = 64'h5EED_0000_0000_1000 + 64'(b);
      dol[b] = 64'h01D0_0000_0000_2000 + 64'(b);
      dc[b]  = 64'hC011_0000_0000_3000 + 64'(b);
    end
    for (int i = 0; i < 16; i++) db[i] = 64'hB000_0000_0000_0000 + 64'(i);

    test_reset();
    test_write_read();
    test_read_unaligned();
`ifndef BMEM_RESP_BACKPRESSURE_EN
    test_back_to_back();
    test_read_then_write();
`endif
    test_reset_mid_burst();
    test_rw_collision();
`ifdef BMEM_RESP_BACKPRESSURE_EN
    test_backpressure();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
